sram_axi_arbiter: RTL and testbench

Shares the single AXI master port of the core between the instruction-fetch and data-memory requesters. Each requester uses an SRAM-like req/addr_ok/data_ok handshake. Exactly one AXI transaction is outstanding at a time, and data has fixed priority over instruction. The block sits between the cache/stall logic of the core and the SoC AXI interconnect.

---
 rtl/sram_axi_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sram_axi_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_arbiter.sv
// Shares one AXI master port between the instruction and data SRAM-like requesters.
// One transaction is outstanding at a time, and data has fixed priority over instruction.
module sram_axi_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);
   localparam logic [3:0] INST_ID = 4'd0;
   localparam logic [3:0] DATA_ID = 4'd1;

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;   // 1 = data side owns the bus
   logic [31:0] addr_q, addr_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] wdata_q, wdata_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;
   logic        inst_data_ok_q, inst_data_ok_d;
   logic        data_data_ok_q, data_data_ok_d;
   logic [31:0] inst_rdata_q, inst_rdata_d;
   logic [31:0] data_rdata_q, data_rdata_d;
   logic [3:0]  cur_id;

   assign cur_id       = owner_q ? DATA_ID : INST_ID;
   assign data_addr_ok = (state_q == IDLE) & data_req;
   assign inst_addr_ok = (state_q == IDLE) & inst_req & ~data_req;

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      addr_d         = addr_q;
      wstrb_d        = wstrb_q;
      wdata_d        = wdata_q;
      awvalid_d      = awvalid_q;
      wvalid_d       = wvalid_q;
      inst_data_ok_d = 1'b0;
      data_data_ok_d = 1'b0;
      inst_rdata_d   = inst_rdata_q;
      data_rdata_d   = data_rdata_q;
      case (state_q)
         IDLE: begin
            if (data_addr_ok) begin
               owner_d = 1'b1;
               addr_d  = data_addr;
               wstrb_d = data_wstrb;
               wdata_d = data_wdata;
               if (data_wr) begin
                  state_d   = WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d = RD_ADDR;
               end
            end else if (inst_addr_ok) begin
               owner_d = 1'b0;
               addr_d  = inst_addr;
               state_d = RD_ADDR;
            end
         end
         RD_ADDR: if (arready) state_d = RD_DATA;
         RD_DATA: begin
            // Beats carrying a foreign rid are consumed and dropped.
            if (rvalid && rlast && (rid == cur_id)) begin
               state_d = IDLE;
               if (owner_q) begin
                  data_rdata_d   = rdata;
                  data_data_ok_d = 1'b1;
               end else begin
                  inst_rdata_d   = rdata;
                  inst_data_ok_d = 1'b1;
               end
            end
         end
         WR_REQ: begin
            if (awready) awvalid_d = 1'b0;
            if (wready)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
         end
         WR_RESP: begin
            if (bvalid) begin
               data_data_ok_d = 1'b1;
               state_d        = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         owner_q        <= 1'b0;
         addr_q         <= '0;
         wstrb_q        <= '0;
         wdata_q        <= '0;
         awvalid_q      <= 1'b0;
         wvalid_q       <= 1'b0;
         inst_data_ok_q <= 1'b0;
         data_data_ok_q <= 1'b0;
         inst_rdata_q   <= '0;
         data_rdata_q   <= '0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         addr_q         <= addr_d;
         wstrb_q        <= wstrb_d;
         wdata_q        <= wdata_d;
         awvalid_q      <= awvalid_d;
         wvalid_q       <= wvalid_d;
         inst_data_ok_q <= inst_data_ok_d;
         data_data_ok_q <= data_data_ok_d;
         inst_rdata_q   <= inst_rdata_d;
         data_rdata_q   <= data_rdata_d;
      end
   end

   assign inst_data_ok = inst_data_ok_q;
   assign data_data_ok = data_data_ok_q;
   assign inst_rdata   = inst_rdata_q;
   assign data_rdata   = data_rdata_q;
   assign arid         = cur_id;
   assign araddr       = addr_q;
   assign arvalid      = (state_q == RD_ADDR);
   assign rready       = (state_q == RD_DATA);
   assign awid         = DATA_ID;
   assign awaddr       = addr_q;
   assign awvalid      = awvalid_q;
   assign wdata        = wdata_q;
   assign wstrb        = wstrb_q;
   assign wvalid       = wvalid_q;
   assign wlast        = wvalid_q;
   assign bready       = (state_q == WR_RESP);
endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Directed bench for sram_axi_arbiter: inputs change 1ns after posedge, outputs sampled 2ns after.
module tb_sram_axi_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic        rlast, rvalid, rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic        awvalid, awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready, bvalid, bready;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sram_axi_arbiter dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Sampling point for the current cycle, after the new inputs have settled.
   task automatic smp();
      #1;
   endtask

   task automatic idle_outs(input string tag);
      chk({tag, "_arvalid"}, 32'(arvalid), 0);
      chk({tag, "_rready"},  32'(rready),  0);
      chk({tag, "_awvalid"}, 32'(awvalid), 0);
      chk({tag, "_wvalid"},  32'(wvalid),  0);
      chk({tag, "_bready"},  32'(bready),  0);
      chk({tag, "_iok"},     32'(inst_data_ok), 0);
      chk({tag, "_dok"},     32'(data_data_ok), 0);
   endtask

   initial begin
      rst = 1'b1;
      inst_req = 0; inst_addr = 0;
      data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
      arready = 0; rid = 0; rdata = 0; rlast = 0; rvalid = 0;
      awready = 0; wready = 0; bvalid = 0;
      nxt(); nxt();
      smp();
      idle_outs("rst");
      chk("rst_irdata", inst_rdata, 0);
      chk("rst_drdata", data_rdata, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_wdata",  wdata, 0);
      chk("rst_wstrb",  32'(wstrb), 0);
      chk("rst_daok",   32'(data_addr_ok), 0);
      rst = 1'b0;

      // Instruction read against a zero-wait slave
      nxt();
      inst_req = 1; inst_addr = 32'hBFC0_0000; smp();
      chk("t1_iaok", 32'(inst_addr_ok), 1);
      chk("t1_daok", 32'(data_addr_ok), 0);
      nxt(); inst_req = 0; arready = 1; smp();
      chk("t1_arvalid", 32'(arvalid), 1);
      chk("t1_arid", 32'(arid), 0);
      chk("t1_araddr", araddr, 32'hBFC0_0000);
      nxt(); arready = 0; rvalid = 1; rlast = 1; rid = 0; rdata = 32'h3C08_0001; smp();
      chk("t1_rready", 32'(rready), 1);
      chk("t1_arvalid_off", 32'(arvalid), 0);
      nxt(); rvalid = 0; smp();
      chk("t1_iok", 32'(inst_data_ok), 1);
      chk("t1_irdata", inst_rdata, 32'h3C08_0001);
      chk("t1_dok", 32'(data_data_ok), 0);
      nxt(); smp();
      chk("t1_iok_pulse", 32'(inst_data_ok), 0);
      chk("t1_irdata_hold", inst_rdata, 32'h3C08_0001);

      // Simultaneous requests: data wins, inst granted alongside data_data_ok
      inst_req = 1; inst_addr = 32'hBFC0_0004;
      data_req = 1; data_wr = 0; data_addr = 32'h8000_1000; smp();
      chk("t2_daok", 32'(data_addr_ok), 1);
      chk("t2_iaok", 32'(inst_addr_ok), 0);
      nxt(); data_req = 0; arready = 1; smp();
      chk("t2_iaok_busy", 32'(inst_addr_ok), 0);
      chk("t2_arid", 32'(arid), 1);
      chk("t2_araddr", araddr, 32'h8000_1000);
      nxt(); arready = 0; rvalid = 1; rid = 1; rdata = 32'hA5A5_0001; smp();
      nxt(); rvalid = 0; smp();
      chk("t2_dok", 32'(data_data_ok), 1);
      chk("t2_drdata", data_rdata, 32'hA5A5_0001);
      chk("t2_iaok_idle", 32'(inst_addr_ok), 1);
      nxt(); inst_req = 0; arready = 1; smp();
      chk("t2_dok_pulse", 32'(data_data_ok), 0);
      chk("t2_arid_inst", 32'(arid), 0);
      chk("t2_araddr_inst", araddr, 32'hBFC0_0004);
      nxt(); arready = 0; rvalid = 1; rid = 0; rdata = 32'h2408_0002; smp();
      nxt(); rvalid = 0; smp();
      chk("t2_iok", 32'(inst_data_ok), 1);
      chk("t2_irdata", inst_rdata, 32'h2408_0002);

      // Write: awready held off three cycles, wready immediate
      nxt();
      data_req = 1; data_wr = 1; data_addr = 32'h8000_2004;
      data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b1100; smp();
      chk("t3_daok", 32'(data_addr_ok), 1);
      nxt(); data_req = 0; data_wr = 0; wready = 1; smp();
      chk("t3_awvalid", 32'(awvalid), 1);
      chk("t3_wvalid", 32'(wvalid), 1);
      chk("t3_wlast", 32'(wlast), 1);
      chk("t3_awid", 32'(awid), 1);
      chk("t3_awaddr", awaddr, 32'h8000_2004);
      chk("t3_wdata", wdata, 32'hDEAD_BEEF);
      chk("t3_wstrb", 32'(wstrb), 32'hC);
      for (int i = 0; i < 2; i++) begin
         nxt(); wready = 0; smp();
         chk("t3_wvalid_off", 32'(wvalid), 0);
         chk("t3_awvalid_hold", 32'(awvalid), 1);
         chk("t3_bready_early", 32'(bready), 0);
      end
      nxt(); awready = 1; smp();
      chk("t3_awvalid_hs", 32'(awvalid), 1);
      nxt(); awready = 0; bvalid = 1; smp();
      chk("t3_awvalid_off", 32'(awvalid), 0);
      chk("t3_bready", 32'(bready), 1);
      chk("t3_dok_early", 32'(data_data_ok), 0);
      nxt(); bvalid = 0; smp();
      chk("t3_dok", 32'(data_data_ok), 1);
      chk("t3_bready_off", 32'(bready), 0);
      nxt(); smp();
      chk("t3_dok_pulse", 32'(data_data_ok), 0);

      // Zero-strobe write, aw and w accepted together
      data_req = 1; data_wr = 1; data_addr = 32'h8000_2008;
      data_wdata = 32'h0000_1111; data_wstrb = 4'b0000; smp();
      nxt(); data_req = 0; data_wr = 0; awready = 1; wready = 1; smp();
      chk("t4_wvalid", 32'(wvalid), 1);
      chk("t4_wstrb", 32'(wstrb), 0);
      nxt(); awready = 0; wready = 0; bvalid = 1; smp();
      chk("t4_bready", 32'(bready), 1);
      nxt(); bvalid = 0; smp();
      chk("t4_dok", 32'(data_data_ok), 1);

      // Slow read: arready low 5 cycles, rvalid low 4 cycles
      nxt();
      data_req = 1; data_addr = 32'h8000_3000; smp();
      chk("t5_daok", 32'(data_addr_ok), 1);
      nxt(); data_req = 0; inst_req = 1; inst_addr = 32'hBFC0_0010; smp();
      for (int i = 0; i < 5; i++) begin
         chk("t5_arvalid", 32'(arvalid), 1);
         chk("t5_araddr", araddr, 32'h8000_3000);
         chk("t5_iaok_busy", 32'(inst_addr_ok), 0);
         nxt(); smp();
      end
      arready = 1; smp();
      chk("t5_arvalid_hs", 32'(arvalid), 1);
      chk("t5_araddr_hs", araddr, 32'h8000_3000);
      nxt(); arready = 0; smp();
      for (int i = 0; i < 4; i++) begin
         chk("t5_rready", 32'(rready), 1);
         chk("t5_dok_early", 32'(data_data_ok), 0);
         chk("t5_iaok_busy2", 32'(inst_addr_ok), 0);
         nxt(); smp();
      end
      inst_req = 0; rvalid = 1; rid = 1; rdata = 32'h0BAD_F00D; smp();
      nxt(); rvalid = 0; smp();
      chk("t5_dok", 32'(data_data_ok), 1);
      chk("t5_drdata", data_rdata, 32'h0BAD_F00D);
      nxt(); smp();
      chk("t5_dok_pulse", 32'(data_data_ok), 0);
      chk("t5_arvalid_idle", 32'(arvalid), 0);

      // Stray beat with foreign rid is dropped
      data_req = 1; data_addr = 32'h8000_4000; smp();
      nxt(); data_req = 0; arready = 1; smp();
      nxt(); arready = 0; rvalid = 1; rid = 5; rdata = 32'hFFFF_FFFF; smp();
      nxt(); rid = 1; rdata = 32'h1234_5678; smp();
      chk("t6_dok_stray", 32'(data_data_ok), 0);
      chk("t6_rready_stay", 32'(rready), 1);
      nxt(); rvalid = 0; smp();
      chk("t6_dok", 32'(data_data_ok), 1);
      chk("t6_drdata", data_rdata, 32'h1234_5678);

      // Reset while in RD_DATA, then a fresh request
      nxt();
      inst_req = 1; inst_addr = 32'hBFC0_0020; smp();
      nxt(); inst_req = 0; arready = 1; smp();
      nxt(); arready = 0; smp();
      chk("t7_rready", 32'(rready), 1);
      rst = 1; smp();
      nxt(); rst = 0; smp();
      idle_outs("t7");
      chk("t7_irdata_rst", inst_rdata, 0);
      inst_req = 1; inst_addr = 32'hBFC0_0030; smp();
      chk("t7_iaok", 32'(inst_addr_ok), 1);
      nxt(); inst_req = 0; arready = 1; smp();
      chk("t7_araddr", araddr, 32'hBFC0_0030);
      nxt(); arready = 0; rvalid = 1; rid = 0; rdata = 32'h1111_2222; smp();
      nxt(); rvalid = 0; smp();
      chk("t7_iok", 32'(inst_data_ok), 1);
      chk("t7_irdata", inst_rdata, 32'h1111_2222);

      nxt();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
